// File: rtl/edge_pkg.sv
// Shared definitions for the multi-channel edge detector: mode encodings,
// per-channel state enum and the edge-to-event mode filter.
package edge_pkg;

    localparam logic [1:0] MODE_FALL = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_BOTH = 2'b10;
    localparam logic [1:0] MODE_OFF  = 2'b11;

    typedef enum logic [1:0] {
        LO     = 2'b00,
        LO_CHK = 2'b01,
        HI     = 2'b10,
        HI_CHK = 2'b11
    } chan_state_e;

    // An accepted edge becomes an event only when the mode asks for it.
    function automatic logic edge_is_event(
        input logic [1:0] mode,
        input logic       rise,
        input logic       fall
    );
        logic v_evt;
        v_evt = 1'b0;
        case (mode)
            MODE_FALL: v_evt = fall;
            MODE_RISE: v_evt = rise;
            MODE_BOTH: v_evt = rise | fall;
            default:   v_evt = 1'b0;
        endcase
        return v_evt;
    endfunction

endpackage

// File: rtl/edge_chan.sv
// One channel: glitch filter FSM, registered event pulse and saturating
// event counter. o_evt_c is the unregistered event for the top-level OR.
module edge_chan
    import edge_pkg::*;
#(
    parameter int unsigned FILT  = 3,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_in,
    input  logic [1:0]       i_mode,
    input  logic             i_clr,
    output logic             o_pulse,
    output logic             o_evt_c,
    output logic [CNT_W-1:0] o_cnt
);

    localparam int unsigned     FCNT_W   = $clog2(FILT + 1);
    localparam logic [FCNT_W-1:0] FILT_V = FCNT_W'(FILT);
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
    localparam bit              FILT_ONE = (FILT == 1);

    chan_state_e        r_state;
    logic [FCNT_W-1:0]  r_fcnt;
    logic               r_pulse;
    logic [CNT_W-1:0]   r_cnt;

    logic [FCNT_W-1:0]  w_fcnt_inc;
    logic               w_done;
    logic               w_rise;
    logic               w_fall;
    logic               w_evt;

    // The candidate level is accepted on the sample that completes FILT in a row.
    assign w_fcnt_inc = r_fcnt + FCNT_W'(1);
    assign w_done     = (w_fcnt_inc == FILT_V);
    assign w_rise     =  i_in && (((r_state == LO) && FILT_ONE) || ((r_state == LO_CHK) && w_done));
    assign w_fall     = !i_in && (((r_state == HI) && FILT_ONE) || ((r_state == HI_CHK) && w_done));
    assign w_evt      = edge_is_event(i_mode, w_rise, w_fall);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LO;
            r_fcnt  <= '0;
            r_pulse <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_pulse <= w_evt;

            // Clear has priority over a coincident event.
            if (i_clr) begin
                r_cnt <= '0;
            end else if (w_evt && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            case (r_state)
                LO: begin
                    if (i_in) begin
                        if (FILT_ONE) begin
                            r_state <= HI;
                            r_fcnt  <= '0;
                        end else begin
                            r_state <= LO_CHK;
                            r_fcnt  <= FCNT_W'(1);
                        end
                    end
                end
                LO_CHK: begin
                    if (!i_in) begin
                        r_state <= LO;
                        r_fcnt  <= '0;
                    end else if (w_done) begin
                        r_state <= HI;
                        r_fcnt  <= '0;
                    end else begin
                        r_fcnt  <= w_fcnt_inc;
                    end
                end
                HI: begin
                    if (!i_in) begin
                        if (FILT_ONE) begin
                            r_state <= LO;
                            r_fcnt  <= '0;
                        end else begin
                            r_state <= HI_CHK;
                            r_fcnt  <= FCNT_W'(1);
                        end
                    end
                end
                HI_CHK: begin
                    if (i_in) begin
                        r_state <= HI;
                        r_fcnt  <= '0;
                    end else if (w_done) begin
                        r_state <= LO;
                        r_fcnt  <= '0;
                    end else begin
                        r_fcnt  <= w_fcnt_inc;
                    end
                end
                default: begin
                    r_state <= LO;
                    r_fcnt  <= '0;
                end
            endcase
        end
    end

    assign o_pulse = r_pulse;
    assign o_evt_c = w_evt;
    assign o_cnt   = r_cnt;

endmodule

// File: rtl/edge_detect_multi.sv
// Multi-channel filtered edge detector: CH edge_chan instances, a registered
// any-event flag and packed per-channel counters.
module edge_detect_multi
    import edge_pkg::*;
#(
    parameter int unsigned CH    = 4,
    parameter int unsigned FILT  = 3,
    parameter int unsigned CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH-1:0]       in,
    input  logic [1:0]          mode,
    input  logic                clr,
    output logic [CH-1:0]       pulse,
    output logic                any_evt,
    output logic [CH*CNT_W-1:0] cnt
);

    logic [CH-1:0]    w_evt;
    logic [CH-1:0]    w_pulse;
    logic [CNT_W-1:0] w_cnt [CH];
    logic             r_any_evt;

    for (genvar g = 0; g < CH; g++) begin : g_chan
        edge_chan #(
            .FILT  (FILT),
            .CNT_W (CNT_W)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .i_in    (in[g]),
            .i_mode  (mode),
            .i_clr   (clr),
            .o_pulse (w_pulse[g]),
            .o_evt_c (w_evt[g]),
            .o_cnt   (w_cnt[g])
        );

        assign cnt[g*CNT_W +: CNT_W] = w_cnt[g];
    end

    // Registered from the same events that load the pulse registers, so it aligns with pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_any_evt <= 1'b0;
        end else begin
            r_any_evt <= |w_evt;
        end
    end

    assign pulse   = w_pulse;
    assign any_evt = r_any_evt;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Bench for edge_detect_multi: two instances (FILT=3 and FILT=1, CNT_W=3)
// driven identically and checked every cycle against a run-length level model.
module tb_edge_detect_multi;

    localparam int CH    = 4;
    localparam int CNT_W = 3;
    localparam int CMAX  = 7;

    logic             clk = 1'b0;
    logic             rst;
    logic [CH-1:0]    in_s;
    logic [1:0]       mode_s;
    logic             clr_s;
    logic [CH-1:0]    pulse_a, pulse_b;
    logic             any_a, any_b;
    logic [CH*CNT_W-1:0] cnt_a, cnt_b;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: [dut][channel]; dut 0 has FILT=3, dut 1 has FILT=1.
    int filt_of [2] = '{3, 1};
    int m_lvl   [2][CH];
    int m_run   [2][CH];
    int m_cnt   [2][CH];
    logic [CH-1:0]       e_pulse [2];
    logic                e_any   [2];
    logic [CH*CNT_W-1:0] e_cnt   [2];

    edge_detect_multi #(.CH(CH), .FILT(3), .CNT_W(CNT_W)) dut_a (
        .clk(clk), .rst(rst), .in(in_s), .mode(mode_s), .clr(clr_s),
        .pulse(pulse_a), .any_evt(any_a), .cnt(cnt_a)
    );

    edge_detect_multi #(.CH(CH), .FILT(1), .CNT_W(CNT_W)) dut_b (
        .clk(clk), .rst(rst), .in(in_s), .mode(mode_s), .clr(clr_s),
        .pulse(pulse_b), .any_evt(any_b), .cnt(cnt_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Predicts outputs after the coming clock edge from the inputs being applied.
    task automatic model_update();
        for (int d = 0; d < 2; d++) begin
            e_any[d] = 1'b0;
            for (int k = 0; k < CH; k++) begin
                logic acc, evt;
                acc = 1'b0;
                evt = 1'b0;
                if (rst) begin
                    m_lvl[d][k] = 0;
                    m_run[d][k] = 0;
                    m_cnt[d][k] = 0;
                end else begin
                    if (int'(in_s[k]) != m_lvl[d][k]) begin
                        m_run[d][k]++;
                        if (m_run[d][k] >= filt_of[d]) begin
                            m_lvl[d][k] = int'(in_s[k]);
                            m_run[d][k] = 0;
                            acc = 1'b1;
                        end
                    end else begin
                        m_run[d][k] = 0;
                    end
                    if (acc) begin
                        evt = (mode_s == 2'd2) ||
                              (mode_s == 2'd1 && m_lvl[d][k] == 1) ||
                              (mode_s == 2'd0 && m_lvl[d][k] == 0);
                    end
                    if (clr_s)
                        m_cnt[d][k] = 0;
                    else if (evt && m_cnt[d][k] < CMAX)
                        m_cnt[d][k]++;
                end
                e_pulse[d][k] = evt;
                e_any[d] = e_any[d] | evt;
                e_cnt[d][k*CNT_W +: CNT_W] = CNT_W'(m_cnt[d][k]);
            end
        end
    endtask

    task automatic step(input logic [CH-1:0] v_in, input logic [1:0] v_mode,
                        input logic v_clr, input logic v_rst);
        in_s   = v_in;
        mode_s = v_mode;
        clr_s  = v_clr;
        rst    = v_rst;
        model_update();
        @(posedge clk);
        @(negedge clk);
        chk("a_pulse", 32'(pulse_a), 32'(e_pulse[0]));
        chk("a_any",   32'(any_a),   32'(e_any[0]));
        chk("a_cnt",   32'(cnt_a),   32'(e_cnt[0]));
        chk("b_pulse", 32'(pulse_b), 32'(e_pulse[1]));
        chk("b_any",   32'(any_b),   32'(e_any[1]));
        chk("b_cnt",   32'(cnt_b),   32'(e_cnt[1]));
    endtask

    initial begin
        logic [CH-1:0] v;
        logic [1:0]    md;

        // Reset
        v = '0;
        step(v, 2'b00, 1'b0, 1'b1);
        step(v, 2'b00, 1'b0, 1'b1);
        chk("rst_pulse", 32'(pulse_a), 32'd0);
        chk("rst_cnt",   32'(cnt_a),   32'd0);

        // Falling-edge mode: rise is filtered silently, fall pulses on third low sample
        v[0] = 1'b1;
        for (int i = 0; i < 5; i++) step(v, 2'b00, 1'b0, 1'b0);
        chk("s1_no_rise_cnt", 32'(cnt_a[0 +: CNT_W]), 32'd0);
        v[0] = 1'b0;
        step(v, 2'b00, 1'b0, 1'b0);
        step(v, 2'b00, 1'b0, 1'b0);
        chk("s1_pulse_early", 32'(pulse_a[0]), 32'd0);
        step(v, 2'b00, 1'b0, 1'b0);
        chk("s1_pulse", 32'(pulse_a[0]), 32'd1);
        step(v, 2'b00, 1'b0, 1'b0);
        chk("s1_pulse_once", 32'(pulse_a[0]), 32'd0);
        chk("s1_cnt", 32'(cnt_a[0 +: CNT_W]), 32'd1);

        // Glitch rejection then a valid rise on ch1, both-edge mode
        v[1] = 1'b1;
        for (int i = 0; i < 2; i++) step(v, 2'b10, 1'b0, 1'b0);
        v[1] = 1'b0;
        for (int i = 0; i < 3; i++) step(v, 2'b10, 1'b0, 1'b0);
        chk("s2_glitch_cnt", 32'(cnt_a[1*CNT_W +: CNT_W]), 32'd0);
        v[1] = 1'b1;
        for (int i = 0; i < 3; i++) step(v, 2'b10, 1'b0, 1'b0);
        chk("s2_pulse", 32'(pulse_a[1]), 32'd1);
        chk("s2_cnt", 32'(cnt_a[1*CNT_W +: CNT_W]), 32'd1);

        // FILT=1 toggle: one pulse per cycle on ch2
        for (int i = 0; i < 6; i++) begin
            v[2] = ~v[2];
            step(v, 2'b10, 1'b0, 1'b0);
            chk("s3_pulse", 32'(pulse_b[2]), 32'd1);
            chk("s3_any", 32'(any_b), 32'd1);
        end
        chk("s3_cnt", 32'(cnt_b[2*CNT_W +: CNT_W]), 32'd6);

        // Saturation on ch3 with a 3-bit counter
        for (int e = 1; e <= 9; e++) begin
            v[3] = 1'b1;
            for (int i = 0; i < 3; i++) step(v, 2'b01, 1'b0, 1'b0);
            chk("s4_pulse", 32'(pulse_a[3]), 32'd1);
            chk("s4_cnt", 32'(cnt_a[3*CNT_W +: CNT_W]), 32'((e > CMAX) ? CMAX : e));
            v[3] = 1'b0;
            for (int i = 0; i < 3; i++) step(v, 2'b01, 1'b0, 1'b0);
        end

        // Clear coincident with events on ch0 and ch1
        v[0] = 1'b1;
        v[1] = 1'b0;
        step(v, 2'b10, 1'b0, 1'b0);
        step(v, 2'b10, 1'b0, 1'b0);
        step(v, 2'b10, 1'b1, 1'b0);
        chk("s5_pulse", 32'(pulse_a[1:0]), 32'd3);
        chk("s5_cnt", 32'(cnt_a[0 +: 2*CNT_W]), 32'd0);

        // Mode off: edges tracked without events, then a falling edge in mode 00
        for (int e = 0; e < 4; e++) begin
            v[0] = ~v[0];
            for (int i = 0; i < 3; i++) step(v, 2'b11, 1'b0, 1'b0);
        end
        chk("s5_off_cnt", 32'(cnt_a[0 +: CNT_W]), 32'd0);
        v[0] = 1'b0;
        for (int i = 0; i < 3; i++) step(v, 2'b00, 1'b0, 1'b0);
        chk("s5_fall_pulse", 32'(pulse_a[0]), 32'd1);

        // Reset mid-filter with the input held high
        v[0] = 1'b1;
        step(v, 2'b01, 1'b0, 1'b0);
        step(v, 2'b01, 1'b0, 1'b0);
        step(v, 2'b01, 1'b0, 1'b1);
        chk("s6_rst_pulse", 32'(pulse_a), 32'd0);
        chk("s6_rst_cnt", 32'(cnt_a), 32'd0);
        for (int i = 0; i < 3; i++) step(v, 2'b01, 1'b0, 1'b0);
        chk("s6_pulse", 32'(pulse_a[0]), 32'd1);
        chk("s6_cnt", 32'(cnt_a[0 +: CNT_W]), 32'd1);

        // Random traffic
        md = 2'b10;
        for (int i = 0; i < 2000; i++) begin
            for (int k = 0; k < CH; k++)
                if ($urandom_range(0, 99) < 30) v[k] = ~v[k];
            if ($urandom_range(0, 99) < 5) md = 2'($urandom_range(0, 3));
            step(v, md, ($urandom_range(0, 99) < 3), ($urandom_range(0, 299) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
